riscv_dp_memif: RTL and testbench

RISCV_DP_MEMIF -- requirements
Module: riscv_dp_memif

---
 rtl/riscv_pkg.sv | 42 ++++
 rtl/riscv_dp_storefmt.sv | 36 +++
 rtl/riscv_dp_memif.sv | 130 +++++++++++++
 tb/tb_riscv_dp_memif.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the data-port memory interface: FSM states,
// RISC-V load/store funct3 codes and byte-enable helpers.
package riscv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } memif_state_e;

    // Byte-enable width of the 32-bit data bus.
    localparam int BE_WIDTH = 4;

    // funct3 codes for loads and stores
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Access size lives in funct3[1:0]; bit 2 only selects zero-extension.
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] offset);
        logic mis;
        mis = 1'b0;
        case (funct3[1:0])
            SIZE_HALF: mis = offset[0];
            SIZE_WORD: mis = (offset != 2'b00);
            default:   mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/riscv_dp_storefmt.sv
// Combinational store formatter: byte enables from size/offset and
// lane replication of the LSB-aligned store data.
module riscv_dp_storefmt
    import riscv_pkg::*;
#(
    parameter int MP_DATA_WIDTH = 32
) (
    input  logic [2:0]               funct3,
    input  logic [1:0]               offset,
    input  logic [MP_DATA_WIDTH-1:0] wdata,
    output logic [BE_WIDTH-1:0]      be,
    output logic [MP_DATA_WIDTH-1:0] fmt_wdata
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        be        = '1;
        fmt_wdata = wdata;
        case (funct3[1:0])
            SIZE_BYTE: begin
                be        = BE_WIDTH'(4'b0001 << offset);
                fmt_wdata = {(MP_DATA_WIDTH/8){wdata[7:0]}};
            end
            SIZE_HALF: begin
                // A half at offset 3 keeps only the lane that fits in the word.
                be        = BE_WIDTH'(4'b0011 << offset);
                fmt_wdata = {(MP_DATA_WIDTH/16){wdata[15:0]}};
            end
            default: begin
                be        = '1;
                fmt_wdata = wdata;
            end
        endcase
    end

endmodule

// File: rtl/riscv_dp_memif.sv
// Data-port memory interface between the core's load/store unit and a
// gnt/rvalid bus. Optional misaligned-access trap: RISCV_MISALIGN_TRAP_EN.
module riscv_dp_memif
    import riscv_pkg::*;
#(
    parameter int MP_DATA_WIDTH = 32,
    parameter int MP_ADDR_WIDTH = 32
) (
    input  logic                     iclk,
    input  logic                     irst,
    input  logic                     ivalid,
    input  logic                     iwe,
    input  logic [2:0]               ifunct3,
    input  logic [MP_ADDR_WIDTH-1:0] iaddr,
    input  logic [MP_DATA_WIDTH-1:0] iwdata,
    output logic                     ostall,
    output logic                     omem_req,
    output logic                     omem_we,
    output logic [MP_ADDR_WIDTH-1:0] omem_addr,
    output logic [BE_WIDTH-1:0]      omem_be,
    output logic [MP_DATA_WIDTH-1:0] omem_wdata,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [MP_DATA_WIDTH-1:0] imem_rdata,
    output logic                     oload_valid,
    output logic [MP_DATA_WIDTH-1:0] oload_data,
    output logic [1:0]               oload_op,
    output logic [2:0]               oload_funct3,
    output logic                     omisalign
);

    memif_state_e              state;
    logic [BE_WIDTH-1:0]       fmt_be;
    logic [MP_DATA_WIDTH-1:0]  fmt_wdata;
    logic                      trap;

    riscv_dp_storefmt #(
        .MP_DATA_WIDTH (MP_DATA_WIDTH)
    ) u_storefmt (
        .funct3    (ifunct3),
        .offset    (iaddr[1:0]),
        .wdata     (iwdata),
        .be        (fmt_be),
        .fmt_wdata (fmt_wdata)
    );

`ifdef RISCV_MISALIGN_TRAP_EN
    assign trap = is_misaligned(ifunct3, iaddr[1:0]);
`else
    assign trap      = 1'b0;
    assign omisalign = 1'b0;
`endif

    // Stall is raised in the accepting cycle itself so the core holds its pipeline.
    assign ostall = (state == ST_REQ) || (state == ST_RESP) ||
                    ((state == ST_IDLE) && ivalid);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state        <= ST_IDLE;
            omem_req     <= 1'b0;
            omem_we      <= 1'b0;
            omem_addr    <= '0;
            omem_be      <= '0;
            omem_wdata   <= '0;
            oload_valid  <= 1'b0;
            oload_data   <= '0;
            oload_op     <= 2'b00;
            oload_funct3 <= 3'b000;
`ifdef RISCV_MISALIGN_TRAP_EN
            omisalign    <= 1'b0;
`endif
        end else begin
            oload_valid <= 1'b0;
`ifdef RISCV_MISALIGN_TRAP_EN
            omisalign   <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (ivalid) begin
                        omem_we      <= iwe;
                        omem_addr    <= {iaddr[MP_ADDR_WIDTH-1:2], 2'b00};
                        omem_be      <= fmt_be;
                        omem_wdata   <= fmt_wdata;
                        oload_op     <= iaddr[1:0];
                        oload_funct3 <= ifunct3;
                        if (trap) begin
`ifdef RISCV_MISALIGN_TRAP_EN
                            omisalign <= 1'b1;
`endif
                            state <= ST_DONE;
                        end else begin
                            omem_req <= 1'b1;
                            state    <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (imem_gnt) begin
                        omem_req <= 1'b0;
                        if (omem_we) begin
                            state <= ST_DONE;
                        end else if (imem_rvalid) begin
                            oload_data  <= imem_rdata;
                            oload_valid <= 1'b1;
                            state       <= ST_DONE;
                        end else begin
                            state <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (imem_rvalid) begin
                        oload_data  <= imem_rdata;
                        oload_valid <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_dp_memif.sv
// Self-checking bench for riscv_dp_memif: directed scenarios plus randomized
// accesses checked against a size/offset arithmetic model.
module tb_riscv_dp_memif;
    import riscv_pkg::*;

    logic        iclk = 1'b0;
    logic        irst;
    logic        ivalid;
    logic        iwe;
    logic [2:0]  ifunct3;
    logic [31:0] iaddr;
    logic [31:0] iwdata;
    logic        ostall;
    logic        omem_req;
    logic        omem_we;
    logic [31:0] omem_addr;
    logic [3:0]  omem_be;
    logic [31:0] omem_wdata;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        oload_valid;
    logic [31:0] oload_data;
    logic [1:0]  oload_op;
    logic [2:0]  oload_funct3;
    logic        omisalign;

    int checks = 0;
    int errors = 0;

    riscv_dp_memif #(
        .MP_DATA_WIDTH (32),
        .MP_ADDR_WIDTH (32)
    ) dut (
        .iclk         (iclk),
        .irst         (irst),
        .ivalid       (ivalid),
        .iwe          (iwe),
        .ifunct3      (ifunct3),
        .iaddr        (iaddr),
        .iwdata       (iwdata),
        .ostall       (ostall),
        .omem_req     (omem_req),
        .omem_we      (omem_we),
        .omem_addr    (omem_addr),
        .omem_be      (omem_be),
        .omem_wdata   (omem_wdata),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .oload_valid  (oload_valid),
        .oload_data   (oload_data),
        .oload_op     (oload_op),
        .oload_funct3 (oload_funct3),
        .omisalign    (omisalign)
    );

    always #5 iclk = ~iclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // Reference model: byte count from funct3, lane mask shifted by offset.
    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        int nbytes;
        int off;
        nbytes = 1 << f3[1:0];
        off    = int'(addr[1:0]);
        if (nbytes >= 4) return 4'hF;
        return 4'(((1 << nbytes) - 1) << off);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] w);
        int nbytes;
        nbytes = 1 << f3[1:0];
        if (nbytes == 1) return {24'b0, w[7:0]} * 32'h0101_0101;
        if (nbytes == 2) return {16'b0, w[15:0]} * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic model_trap(input logic [2:0] f3, input logic [31:0] addr);
`ifdef RISCV_MISALIGN_TRAP_EN
        int nbytes;
        nbytes = 1 << f3[1:0];
        return (int'(addr[1:0]) % nbytes) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [109:0] all_outputs();
        return {ostall, omem_req, omem_we, omem_addr, omem_be, omem_wdata,
                oload_valid, oload_data, oload_op, oload_funct3, omisalign};
    endfunction

    // One full transaction; starts and ends 1ns after a rising edge with the DUT idle.
    task automatic do_txn(input string name, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int gnt_dly, input int rv_dly, input logic [31:0] rdata);
        logic [70:0] got_bus;
        logic [70:0] exp_bus;
        logic        mis;
        mis     = model_trap(f3, addr);
        exp_bus = {1'b1, 1'b1, we, addr & 32'hFFFF_FFFC, model_be(f3, addr), model_wdata(f3, wdata)};

        ivalid  = 1'b1;
        iwe     = we;
        ifunct3 = f3;
        iaddr   = addr;
        iwdata  = wdata;
        @(negedge iclk);
        checks++;
        if (ostall !== 1'b1) begin
            errors++;
            $display("FAIL %s accept_stall got %0b exp 1", name, ostall);
        end
        @(posedge iclk); #1;
        ivalid = 1'b0;
        iaddr  = $urandom;
        iwdata = $urandom;

        if (mis) begin
            @(negedge iclk);
            checks++;
            if ({ostall, omisalign, omem_req, oload_valid} !== 4'b0100) begin
                errors++;
                $display("FAIL %s trap_done got %b exp 0100", name,
                         {ostall, omisalign, omem_req, oload_valid});
            end
        end else begin
            for (int w = 0; w <= gnt_dly; w++) begin
                imem_gnt    = (w == gnt_dly);
                imem_rvalid = (w == gnt_dly) && !we && (rv_dly == 0);
                imem_rdata  = imem_rvalid ? rdata : $urandom;
                @(negedge iclk);
                got_bus = {ostall, omem_req, omem_we, omem_addr, omem_be, omem_wdata};
                checks++;
                if (got_bus !== exp_bus) begin
                    errors++;
                    $display("FAIL %s req_bus[%0d] got %h exp %h", name, w, got_bus, exp_bus);
                end
                @(posedge iclk); #1;
                imem_gnt    = 1'b0;
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom;
            end
            if (!we && rv_dly > 0) begin
                for (int r = 1; r <= rv_dly; r++) begin
                    imem_rvalid = (r == rv_dly);
                    imem_rdata  = imem_rvalid ? rdata : $urandom;
                    @(negedge iclk);
                    checks++;
                    if ({ostall, omem_req, oload_valid} !== 3'b100) begin
                        errors++;
                        $display("FAIL %s resp_wait got %b exp 100", name,
                                 {ostall, omem_req, oload_valid});
                    end
                    @(posedge iclk); #1;
                    imem_rvalid = 1'b0;
                    imem_rdata  = $urandom;
                end
            end
            @(negedge iclk);
            checks++;
            if ({ostall, oload_valid, omisalign, omem_req} !== {1'b0, !we, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL %s done_flags got %b exp %b", name,
                         {ostall, oload_valid, omisalign, omem_req}, {1'b0, !we, 1'b0, 1'b0});
            end
            if (!we) begin
                checks++;
                if (oload_data !== rdata) begin
                    errors++;
                    $display("FAIL %s load_data got %h exp %h", name, oload_data, rdata);
                end
            end
        end
        checks++;
        if ({oload_op, oload_funct3} !== {addr[1:0], f3}) begin
            errors++;
            $display("FAIL %s op_funct3 got %b exp %b", name, {oload_op, oload_funct3}, {addr[1:0], f3});
        end

        @(posedge iclk); #1;
        @(negedge iclk);
        checks++;
        if ({ostall, oload_valid, omisalign, omem_req, oload_op} !== {4'b0000, addr[1:0]}) begin
            errors++;
            $display("FAIL %s idle_after got %b exp %b", name,
                     {ostall, oload_valid, omisalign, omem_req, oload_op}, {4'b0000, addr[1:0]});
        end
        @(posedge iclk); #1;
    endtask

    task automatic test_reset();
        irst = 1'b1;
        ivalid = 1'b0; iwe = 1'b0; ifunct3 = 3'b000; iaddr = '0; iwdata = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        repeat (2) @(negedge iclk);
        checks++;
        if (all_outputs() !== '0) begin
            errors++;
            $display("FAIL reset_state got %h exp 0", all_outputs());
        end
        irst = 1'b0;
        @(posedge iclk); #1;
    endtask

    task automatic test_directed();
        do_txn("sw_0x100", 1'b1, F3_SW, 32'h100, 32'hDEAD_BEEF, 0, 0, '0);
        do_txn("sb_0x103", 1'b1, F3_SB, 32'h103, 32'h0000_00A5, 0, 0, '0);
        do_txn("lh_0x202", 1'b0, F3_LH, 32'h202, 32'h0, 3, 1, 32'h8001_0000);
        do_txn("lw_same",  1'b0, F3_LW, 32'h100, 32'h0, 0, 0, 32'h1234_5678);
        do_txn("sh_0x103", 1'b1, F3_SH, 32'h103, 32'h0000_BEEF, 1, 0, '0);
    endtask

    task automatic test_misalign();
        do_txn("lw_0x101", 1'b0, F3_LW, 32'h101, 32'h0, 0, 1, 32'hA1B2_C3D4);
    endtask

    task automatic test_reset_resp();
        ivalid = 1'b1; iwe = 1'b0; ifunct3 = F3_LHU; iaddr = 32'h302; iwdata = '0;
        @(posedge iclk); #1;
        ivalid = 1'b0;
        imem_gnt = 1'b1;
        @(posedge iclk); #1;
        imem_gnt = 1'b0;
        @(negedge iclk);
        checks++;
        if ({ostall, omem_req, oload_op} !== 4'b1010) begin
            errors++;
            $display("FAIL rst_resp_pre got %b exp 1010", {ostall, omem_req, oload_op});
        end
        @(posedge iclk); #1;
        irst = 1'b1;
        #1;
        checks++;
        if (all_outputs() !== '0) begin
            errors++;
            $display("FAIL rst_resp_async got %h exp 0", all_outputs());
        end
        @(negedge iclk);
        irst = 1'b0;
        @(posedge iclk); #1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_F00D;
        @(negedge iclk);
        checks++;
        if (all_outputs() !== '0) begin
            errors++;
            $display("FAIL rst_late_rvalid got %h exp 0", all_outputs());
        end
        @(posedge iclk); #1;
        imem_rvalid = 1'b0;
        @(negedge iclk);
        checks++;
        if ({oload_valid, oload_data} !== 33'h0) begin
            errors++;
            $display("FAIL rst_after got %h exp 0", {oload_valid, oload_data});
        end
        @(posedge iclk); #1;
    endtask

    task automatic test_back_to_back();
        ivalid = 1'b1; iwe = 1'b1; ifunct3 = F3_SW; iaddr = 32'h400; iwdata = 32'h1122_3344;
        @(posedge iclk); #1;
        imem_gnt = 1'b1;
        @(posedge iclk); #1;
        imem_gnt = 1'b0;
        iaddr  = 32'h500;
        iwdata = 32'h5566_7788;
        @(negedge iclk);
        checks++;
        if ({ostall, omem_req} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_done got %b exp 00", {ostall, omem_req});
        end
        @(posedge iclk); #1;
        @(negedge iclk);
        checks++;
        if ({ostall, omem_req} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_idle_accept got %b exp 10", {ostall, omem_req});
        end
        @(posedge iclk); #1;
        ivalid   = 1'b0;
        imem_gnt = 1'b1;
        @(negedge iclk);
        checks++;
        if ({omem_req, omem_addr, omem_wdata} !== {1'b1, 32'h500, 32'h5566_7788}) begin
            errors++;
            $display("FAIL b2b_second_req got %h exp %h", {omem_req, omem_addr, omem_wdata},
                     {1'b1, 32'h500, 32'h5566_7788});
        end
        @(posedge iclk); #1;
        imem_gnt = 1'b0;
        @(posedge iclk); #1;
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic        we;
        logic [31:0] addr;
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom_range(0, 1));
            if (we) begin
                case ($urandom_range(0, 2))
                    0:       f3 = F3_SB;
                    1:       f3 = F3_SH;
                    default: f3 = F3_SW;
                endcase
            end else begin
                case ($urandom_range(0, 4))
                    0:       f3 = F3_LB;
                    1:       f3 = F3_LH;
                    2:       f3 = F3_LW;
                    3:       f3 = F3_LBU;
                    default: f3 = F3_LHU;
                endcase
            end
            addr = $urandom;
            do_txn($sformatf("rand%0d", i), we, f3, addr, $urandom,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), $urandom);
            repeat ($urandom_range(0, 2)) @(posedge iclk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_misalign();
        test_reset_resp();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
